// File: rtl/soc_system_pio_pkg.sv
// rtl/soc_system_pio_pkg.sv - register map and edge-type encoding shared by the PIO blocks
package soc_system_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_pio_sync.sv
// rtl/soc_system_pio_sync.sv - WIDTH-bit input synchronizer
// PIO_RETORNO_SYNC_EN selects two flops (meta, sync); otherwise a single sync register.
module soc_system_pio_sync #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] sync_q;

`ifdef PIO_RETORNO_SYNC_EN
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] meta_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end
`else
    always_comb begin
        sync_d = d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end
`endif

    assign q = sync_q;

endmodule

// File: rtl/soc_system_pio_retorno.sv
// rtl/soc_system_pio_retorno.sv - status input PIO with sticky edge capture and maskable irq
// Synchronizer depth follows PIO_RETORNO_SYNC_EN (see soc_system_pio_sync).
module soc_system_pio_retorno
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH     = 15,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] rd_mux;
    logic             bus_wr;

    logic [WIDTH-1:0] prev_d,     prev_q;
    logic [WIDTH-1:0] irqmask_d,  irqmask_q;
    logic [WIDTH-1:0] edgecap_d,  edgecap_q;
    logic [31:0]      readdata_d, readdata_q;

    soc_system_pio_sync #(.WIDTH(WIDTH)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync)
    );

    generate
        if (WIDTH < 32) begin : g_wd_unused
            logic wd_unused;
            assign wd_unused = ^writedata[31:WIDTH];
        end
    endgenerate

    assign bus_wr = chipselect && !write_n;

    always_comb begin
        edges = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edges = sync & ~prev_q;
            EDGE_FALL: edges = ~sync & prev_q;
            default:   edges = sync ^ prev_q;
        endcase
    end

    always_comb begin
        prev_d    = sync;
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (bus_wr && address == PIO_ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (bus_wr && address == PIO_ADDR_EDGECAP) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        // A fresh edge overrides a same-cycle clear so no event is lost.
        edgecap_d = edgecap_d | edges;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            PIO_ADDR_DATA:    rd_mux = sync;
            PIO_ADDR_IRQMASK: rd_mux = irqmask_q;
            PIO_ADDR_EDGECAP: rd_mux = edgecap_q;
            default:          rd_mux = '0;
        endcase
        readdata_d = readdata_q;
        if (chipselect && write_n) begin
            readdata_d             = '0;
            readdata_d[WIDTH-1:0]  = rd_mux;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= prev_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule
